// File: rtl/comparador_serial_der_izq_if.sv
// Handshake/data bundle for the bit-serial comparator: operands and start in,
// status, result and per-bit debug out. fsm_state and cell_p expose internals.
interface comparador_serial_der_izq_if #(
    parameter int N = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // start is a request sampled only while idle; there is no ready, busy=1
    // means any start is dropped, and done is a single-cycle result strobe.
    logic          start;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic          busy;
    logic          done;
    logic          a_le_b;
    logic          ai_ser;
    logic          bi_ser;
    logic [IW-1:0] bit_idx;
    logic [1:0]    fsm_state;
    logic          cell_p;

    modport master (
        output start, A, B,
        input  busy, done, a_le_b, ai_ser, bi_ser, bit_idx, fsm_state, cell_p
    );

    modport slave (
        input  start, A, B,
        output busy, done, a_le_b, ai_ser, bi_ser, bit_idx, fsm_state, cell_p
    );
endinterface

// File: rtl/comparador_serial_der_izq.sv
// Bit-serial A <= B comparator: one right-to-left comparison cell evaluated
// N times over LSB-first shifted operands, with its state held in a register.
module comparador_serial_der_izq #(
    parameter int N = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    comparador_serial_der_izq_if.slave    bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic          p;
    logic          p_next;
    logic          a_le_b_q;
    logic [IW-1:0] bit_idx_q;

    // Cell: in state a (p=1) stay while ai <= bi; in state b only a strictly
    // smaller A bit brings it back. Higher bits overwrite lower history.
    always_comb begin
        p_next    = p ? (sa[0] <= sb[0]) : (sa[0] < sb[0]);
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (bit_idx_q == LAST_IDX) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            p         <= 1'b1;
            a_le_b_q  <= 1'b0;
            bit_idx_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa        <= bus.A;
                        sb        <= bus.B;
                        p         <= 1'b1;
                        bit_idx_q <= '0;
                    end
                end
                SHIFT: begin
                    p  <= p_next;
                    sa <= sa >> 1;
                    sb <= sb >> 1;
                    // Index saturates on the last bit so N=1 keeps it at 0.
                    if (bit_idx_q == LAST_IDX) begin
                        a_le_b_q <= p_next;
                    end else begin
                        bit_idx_q <= bit_idx_q + 1'b1;
                    end
                end
                DONE: bit_idx_q <= '0;
                default: bit_idx_q <= '0;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.a_le_b    = a_le_b_q;
    assign bus.ai_ser    = (state == SHIFT) ? sa[0] : 1'b0;
    assign bus.bi_ser    = (state == SHIFT) ? sb[0] : 1'b0;
    assign bus.bit_idx   = bit_idx_q;
    assign bus.fsm_state = state;
    assign bus.cell_p    = p;
endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// Bench for the bit-serial comparator: an N=8 and an N=1 instance, expected
// results queued at start and compared on done.
module tb_comparador_serial_der_izq;
    localparam int N8 = 8;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;
    logic exp_q[$];

    comparador_serial_der_izq_if #(.N(N8)) bus8 ();
    comparador_serial_der_izq_if #(.N(1))  bus1 ();

    comparador_serial_der_izq #(.N(N8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    comparador_serial_der_izq #(.N(1))  dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        reset = 1'b1;
        bus8.start = 1'b1;
        bus8.A = 8'h00;
        bus8.B = 8'hFF;
        bus1.start = 1'b0;
        bus1.A = 1'b0;
        bus1.B = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        bus8.start = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.a_le_b !== 1'b0 ||
            bus8.bit_idx !== 3'd0 || bus8.ai_ser !== 1'b0 || bus8.bi_ser !== 1'b0 ||
            bus8.cell_p !== 1'b1 || bus8.fsm_state !== 2'd0)
            $display("FAIL reset8 got busy=%b done=%b a_le_b=%b idx=%0d ai=%b bi=%b p=%b st=%0d exp 0 0 0 0 0 0 1 0",
                     bus8.busy, bus8.done, bus8.a_le_b, bus8.bit_idx, bus8.ai_ser, bus8.bi_ser,
                     bus8.cell_p, bus8.fsm_state);
        else n_pass++;
        n_total++;
        if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.a_le_b !== 1'b0 || bus1.cell_p !== 1'b1)
            $display("FAIL reset1 got busy=%b done=%b a_le_b=%b p=%b exp 0 0 0 1",
                     bus1.busy, bus1.done, bus1.a_le_b, bus1.cell_p);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    // Runs one N=8 comparison; optionally checks the serial bits and cell trace.
    task automatic do_compare8(input logic [7:0] a, input logic [7:0] b, input bit trace);
        logic p_m;
        logic exp;
        bit   got_done;
        exp_q.push_back(a <= b);
        bus8.start = 1'b1;
        bus8.A = a;
        bus8.B = b;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        bus8.A = 8'($urandom_range(0, 255));
        bus8.B = 8'($urandom_range(0, 255));
        p_m = 1'b1;
        got_done = 1'b0;
        for (int k = 1; k <= N8 + 4 && !got_done; k++) begin
            @(negedge clk);
            if (bus8.done) begin
                got_done = 1'b1;
                exp = exp_q.pop_front();
                n_total++;
                if (k != N8 + 1) $display("FAIL done_latency got=%0d exp=%0d", k, N8 + 1);
                else n_pass++;
                n_total++;
                if (bus8.a_le_b !== exp)
                    $display("FAIL result a=%h b=%h got=%b exp=%b", a, b, bus8.a_le_b, exp);
                else n_pass++;
                n_total++;
                if (bus8.busy !== 1'b1) $display("FAIL busy_done got=%b exp=1", bus8.busy);
                else n_pass++;
            end else begin
                n_total++;
                if (bus8.busy !== 1'b1) $display("FAIL busy_shift k=%0d got=%b exp=1", k, bus8.busy);
                else n_pass++;
                if (trace && k <= N8) begin
                    n_total++;
                    if (bus8.bit_idx !== 3'(k - 1) || bus8.ai_ser !== a[k-1] ||
                        bus8.bi_ser !== b[k-1] || bus8.cell_p !== p_m)
                        $display("FAIL trace k=%0d got idx=%0d ai=%b bi=%b p=%b exp idx=%0d ai=%b bi=%b p=%b",
                                 k, bus8.bit_idx, bus8.ai_ser, bus8.bi_ser, bus8.cell_p,
                                 k - 1, a[k-1], b[k-1], p_m);
                    else n_pass++;
                    p_m = p_m ? (a[k-1] <= b[k-1]) : (a[k-1] < b[k-1]);
                end
            end
        end
        if (!got_done) begin
            n_total++;
            $display("FAIL done_timeout a=%h b=%h got=no_done exp=done", a, b);
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        n_total++;
        if (bus8.busy !== 1'b0 || bus8.a_le_b !== (a <= b))
            $display("FAIL idle_hold got busy=%b a_le_b=%b exp busy=0 a_le_b=%b",
                     bus8.busy, bus8.a_le_b, (a <= b));
        else n_pass++;
    endtask

    task automatic test_compare();
        do_compare8(8'h5A, 8'h5A, 1'b1);
        do_compare8(8'h80, 8'h7F, 1'b1);
        do_compare8(8'h7F, 8'h80, 1'b1);
        do_compare8(8'h01, 8'h00, 1'b1);
        do_compare8(8'hFE, 8'hFF, 1'b1);
        for (int i = 0; i < 6; i++)
            do_compare8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic test_back_to_back();
        int   n_done;
        logic exp;
        n_done = 0;
        exp_q.push_back(1'b0);
        bus8.start = 1'b1;
        bus8.A = 8'd3;
        bus8.B = 8'd2;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 2 * N8 + 3; k++) begin
            @(negedge clk);
            if (k == 3) begin
                bus8.A = 8'd0;
                exp_q.push_back(1'b1);
            end
            if (k == 2 * N8 + 3) bus8.start = 1'b0;
            if (bus8.done) begin
                n_done++;
                exp = exp_q.pop_front();
                n_total++;
                if (k != N8 + 1 && k != 2 * N8 + 3)
                    $display("FAIL b2b_done_pos got=%0d exp=%0d_or_%0d", k, N8 + 1, 2 * N8 + 3);
                else n_pass++;
                n_total++;
                if (bus8.a_le_b !== exp)
                    $display("FAIL b2b_result k=%0d got=%b exp=%b", k, bus8.a_le_b, exp);
                else n_pass++;
            end
        end
        n_total++;
        if (n_done != 2) $display("FAIL b2b_count got=%0d exp=2", n_done);
        else n_pass++;
        while (exp_q.size() > 0) void'(exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        int   n_done;
        bit   hit;
        n_done = 0;
        hit = 1'b0;
        bus8.start = 1'b1;
        bus8.A = 8'hFF;
        bus8.B = 8'h00;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        for (int k = 0; k < N8 + 4 && !hit; k++) begin
            @(negedge clk);
            if (bus8.done) n_done++;
            if (bus8.bit_idx == 3'd4 && bus8.busy) hit = 1'b1;
        end
        n_total++;
        if (!hit) $display("FAIL abort_reach got=no_idx4 exp=idx4");
        else n_pass++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.a_le_b !== 1'b0 ||
            bus8.bit_idx !== 3'd0 || bus8.ai_ser !== 1'b0 || bus8.bi_ser !== 1'b0 || bus8.cell_p !== 1'b1)
            $display("FAIL abort_state got busy=%b done=%b a_le_b=%b idx=%0d ai=%b bi=%b p=%b exp 0 0 0 0 0 0 1",
                     bus8.busy, bus8.done, bus8.a_le_b, bus8.bit_idx, bus8.ai_ser, bus8.bi_ser, bus8.cell_p);
        else n_pass++;
        for (int k = 0; k < N8 + 3; k++) begin
            @(negedge clk);
            if (bus8.done) n_done++;
        end
        n_total++;
        if (n_done != 0) $display("FAIL abort_no_done got=%0d exp=0", n_done);
        else n_pass++;
        @(posedge clk);
        #1;
        do_compare8(8'd1, 8'd2, 1'b1);
    endtask

    task automatic do_compare1(input logic a, input logic b);
        logic exp;
        bit   got_done;
        exp_q.push_back(a <= b);
        bus1.start = 1'b1;
        bus1.A = a;
        bus1.B = b;
        @(posedge clk);
        #1;
        bus1.start = 1'b0;
        bus1.A = ~a;
        bus1.B = ~b;
        got_done = 1'b0;
        for (int k = 1; k <= 5 && !got_done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_total++;
                if (bus1.bit_idx !== 1'b0 || bus1.ai_ser !== a || bus1.bi_ser !== b)
                    $display("FAIL n1_serial got idx=%b ai=%b bi=%b exp 0 %b %b",
                             bus1.bit_idx, bus1.ai_ser, bus1.bi_ser, a, b);
                else n_pass++;
            end
            if (bus1.done) begin
                got_done = 1'b1;
                exp = exp_q.pop_front();
                n_total++;
                if (k != 2) $display("FAIL n1_latency got=%0d exp=2", k);
                else n_pass++;
                n_total++;
                if (bus1.a_le_b !== exp)
                    $display("FAIL n1_result a=%b b=%b got=%b exp=%b", a, b, bus1.a_le_b, exp);
                else n_pass++;
            end
        end
        if (!got_done) begin
            n_total++;
            $display("FAIL n1_timeout a=%b b=%b got=no_done exp=done", a, b);
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_n1();
        do_compare1(1'b0, 1'b0);
        do_compare1(1'b0, 1'b1);
        do_compare1(1'b1, 1'b0);
        do_compare1(1'b1, 1'b1);
    endtask

    initial begin
        n_total = 0;
        n_pass = 0;
        test_reset();
        test_compare();
        test_back_to_back();
        test_reset_abort();
        test_n1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
